demux_stream_router: RTL and testbench
======================================

Name: demux_stream_router

Overview:
- Parametrised, clocked successor to the 1-to-8 combinational demultiplexer.
- Routes a valid/ready input stream to one of NUM_CH output channels selected by in_sel, or to all channels in broadcast mode.
- Each channel has its own first-word-fall-through FIFO, so a stalled consumer does not block traffic to other channels once its own FIFO has space.
- Sits between a single producer and NUM_CH independent consumers.

Parameters:
- DATA_W, 8, width of each data word.
- NUM_CH, 8, number of output channels; must be >= 2.
- SEL_W, 3, width of in_sel; requires 2**SEL_W >= NUM_CH.
- DEPTH, 4, entries per channel FIFO; power of two, >= 2.
- ERR_W, 8, width of the illegal-select counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  router accepts the word this cycle.
- in_data  input  DATA_W  input word.
- in_sel  input  SEL_W  destination channel index; ignored when in_bcast=1.
- in_bcast  input  1  broadcast the word to every channel.
- out_valid  output  NUM_CH  bit k set when channel k FIFO is non-empty.
- out_ready  input  NUM_CH  bit k set when consumer k takes the head word.
- out_data  output  NUM_CH*DATA_W  channel k head word at bits [k*DATA_W +: DATA_W].
- err_cnt  output  ERR_W  saturating count of dropped illegal-select words.

Behaviour:
- Design rules: one clock; reset is synchronous and active-low, with clk and rst_n as the port names. There are no asynchronous paths.
- Reset (rst_n=0 at a clk edge):
  - All FIFO pointers and counts clear.
  - out_valid = 0, err_cnt = 0.
  - All FIFO contents are discarded, including on reset mid-operation.
- While rst_n=0, in_ready is forced to 0.
- out_data slice k is 0 whenever out_valid[k]=0.
- Accept rule: accept = in_valid & in_ready. in_ready is combinational from the FIFO full flags and the request fields, and never depends on in_valid.
- in_ready by mode:
  - Unicast, legal select (in_bcast=0, in_sel < NUM_CH): in_ready = !full[in_sel].
  - Broadcast (in_bcast=1): in_ready = 1 only if no channel is full. The word is written to all NUM_CH FIFOs in the same cycle (all or none).
  - Unicast, illegal select (in_sel >= NUM_CH): in_ready = 1. The word is dropped and err_cnt increments by 1, saturating at 2**ERR_W-1 with no wrap.
- Latency: a word accepted at edge N is visible on out_valid/out_data of its channel(s) immediately after edge N, i.e. 1 cycle.
- Pop: when out_valid[k] & out_ready[k] at an edge, the channel k head advances. out_ready[k] while empty has no effect.
- Full FIFO: in_ready uses the current full flag only. A pop in the same cycle does not free space for a same-cycle push, so a full channel refuses input for that cycle.
- Simultaneous push and pop on a channel that is neither full nor empty: count is unchanged, both pointers advance.
- Simultaneous push and pop on an empty channel: there is no pop, because out_valid was 0; count becomes 1.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1, range 0..DEPTH.
- Ordering: per-channel FIFO order is strict. No ordering is guaranteed between channels.
- Holding a request: while in_valid=1 and in_ready=0, the producer holds in_data/in_sel/in_bcast stable. The router does not rely on this for correctness.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=8'h00, err_cnt=0. After release, in_ready=1 with no traffic.
2. Unicast fill/drain: push 0xA0..0xA4 to sel=3 with out_ready=0 -> first 4 accepted and the 5th refused (in_ready=0). Then raise out_ready[3] -> out_data[3] shows A0, A1, A2, A3 on consecutive cycles, and out_valid[3] drops after A3.
3. Broadcast blocking: fill channel 5 (DEPTH words), then send bcast 0x55 -> in_ready=0 and no channel receives it. Pop one word from channel 5 -> next cycle 0x55 is accepted and appears on all 8 channels together.
4. Illegal select (NUM_CH=6, SEL_W=3): send sel=6 and sel=7 -> both accepted, err_cnt=2, out_valid unchanged. With ERR_W=2, send 5 illegal words -> err_cnt stays at 3.
5. Concurrent push/pop: channel 1 holding 2 words, push and pop in the same cycle for 10 cycles -> count stays 2, data order is preserved, and the pointers wrap correctly past DEPTH.
6. Reset mid-operation: channels 0 and 2 partially full, assert rst_n=0 for one edge -> all out_valid=0 next cycle. Subsequent pushes appear with no stale data.

Source files
------------

// File: rtl/demux_stream_router.sv
// Valid/ready stream router: one producer fanned out to NUM_CH per-channel
// first-word-fall-through FIFOs, by channel select or broadcast.

module demux_stream_router_lane #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              rdy,
  output logic              vld,
  output logic              full,
  output logic [DATA_W-1:0] dout
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [PTR_W:0]               cnt;
  logic                         do_push, do_pop;

  assign vld     = (cnt != '0);
  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = vld & rdy;
  // Head is masked so a drained channel never exposes stale data.
  assign dout    = vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module demux_stream_router #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 4,
  parameter int ERR_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [ERR_W-1:0]         err_cnt
);
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0]      full, push;
  logic [2**SEL_W-1:0]    full_ext;
  logic                   legal, accept;

  assign legal  = ({1'b0, in_sel} < NCH);
  assign accept = in_valid & in_ready;

  // Zero-padded copy lets the select index every code without range issues.
  always_comb begin
    full_ext               = '0;
    full_ext[NUM_CH-1:0]   = full;
  end

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (in_bcast)   in_ready = ~|full;
      else if (legal) in_ready = ~full_ext[in_sel];
      else            in_ready = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (accept && !in_bcast && !legal && err_cnt != {ERR_W{1'b1}})
      err_cnt <= err_cnt + 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push[k] = accept & (in_bcast | (legal & (in_sel == SEL_W'(k))));

    demux_stream_router_lane #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push[k]),
      .din  (in_data),
      .rdy  (out_ready[k]),
      .vld  (out_valid[k]),
      .full (full[k]),
      .dout (out_data[k*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_demux_stream_router.sv
// Bench for demux_stream_router: table-driven cycles checked against a
// per-channel queue model, plus a hand sequence on a 6-channel instance.

module tb_demux_stream_router;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_bcast;
  logic [7:0]  in_data, out_valid, out_ready, err_cnt;
  logic [2:0]  in_sel;
  logic [63:0] out_data;

  logic        v6, rdy6, b6;
  logic [7:0]  d6;
  logic [2:0]  s6;
  logic [5:0]  ov6, or6;
  logic [47:0] od6;
  logic [1:0]  err6;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_stream_router dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_cnt(err_cnt)
  );

  demux_stream_router #(.NUM_CH(6), .ERR_W(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6),
    .in_data(d6), .in_sel(s6), .in_bcast(b6),
    .out_valid(ov6), .out_ready(or6), .out_data(od6), .err_cnt(err6)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic [2:0] s;
    logic       b;
    logic [7:0] r;
    logic       er;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] q[0:7][$];
  logic [5:0] m6 = '0;
  logic [1:0] e6 = '0;

  function automatic void add(logic rst, logic v, logic [7:0] d, logic [2:0] s,
                              logic b, logic [7:0] r, logic er);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.s = s; t.b = b; t.r = r; t.er = er;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    logic mr;
    logic full_any;
    rst_n = !t.rst; in_valid = t.v; in_data = t.d; in_sel = t.s;
    in_bcast = t.b; out_ready = t.r;
    @(negedge clk);
    full_any = 1'b0;
    for (int k = 0; k < 8; k++) if (q[k].size() >= 4) full_any = 1'b1;
    if (t.rst)    mr = 1'b0;
    else if (t.b) mr = !full_any;
    else          mr = (q[t.s].size() < 4);
    chk("tbl_ready", {31'd0, in_ready}, {31'd0, t.er});
    chk("mdl_ready", {31'd0, in_ready}, {31'd0, mr});
    chk("err_cnt", {24'd0, err_cnt}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      logic       ev;
      logic [7:0] ed;
      ev = (q[k].size() != 0);
      ed = ev ? q[k][0] : 8'h00;
      chk($sformatf("out_valid%0d", k), {31'd0, out_valid[k]}, {31'd0, ev});
      chk($sformatf("out_data%0d", k), {24'd0, out_data[k*8 +: 8]}, {24'd0, ed});
    end
    @(posedge clk);
    if (t.rst) begin
      for (int k = 0; k < 8; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 8; k++)
        if (t.r[k] && q[k].size() != 0) void'(q[k].pop_front());
      if (t.v && mr) begin
        if (t.b) for (int k = 0; k < 8; k++) q[k].push_back(t.d);
        else     q[t.s].push_back(t.d);
      end
    end
    #1;
  endtask

  task automatic cyc6(input logic v, input logic [7:0] d, input logic [2:0] s,
                      input logic b, input logic er);
    v6 = v; d6 = d; s6 = s; b6 = b;
    @(negedge clk);
    chk("ready6", {31'd0, rdy6}, {31'd0, er});
    chk("err6", {30'd0, err6}, {30'd0, e6});
    chk("out_valid6", {26'd0, ov6}, {26'd0, m6});
    @(posedge clk);
    if (v && er) begin
      if (b)                m6 = 6'h3F;
      else if (s < 3'd6)    m6[s] = 1'b1;
      else if (e6 != 2'd3)  e6 = e6 + 2'd1;
    end
    #1;
  endtask

  initial begin
    // 1: reset with a pending broadcast, then idle
    add(1, 1, 8'hEE, 0, 1, 8'h00, 0);
    add(1, 1, 8'hEE, 0, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 1);
    // 2: fill channel 3, fifth word refused, then drain
    for (int i = 0; i < 5; i++) add(0, 1, 8'hA0 + 8'(i), 3, 0, 8'h00, i < 4);
    for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 0, 0, 8'h08, 1);
    // 3: broadcast blocked by full channel 5 until it pops
    for (int i = 0; i < 4; i++) add(0, 1, 8'hC0 + 8'(i), 5, 0, 8'h00, 1);
    add(0, 1, 8'h55, 0, 1, 8'h00, 0);
    add(0, 1, 8'h55, 0, 1, 8'h20, 0);
    add(0, 1, 8'h55, 0, 1, 8'h00, 1);
    add(0, 0, 8'h00, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 0, 0, 8'hFF, 1);
    // 5: steady push+pop on channel 1, pointers wrap several times
    add(0, 1, 8'hB0, 1, 0, 8'h00, 1);
    add(0, 1, 8'hB1, 1, 0, 8'h00, 1);
    for (int i = 2; i < 12; i++) add(0, 1, 8'hB0 + 8'(i), 1, 0, 8'h02, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 0, 8'h02, 1);
    // 6: reset mid-operation discards contents
    add(0, 1, 8'h11, 0, 0, 8'h00, 1);
    add(0, 1, 8'h12, 0, 0, 8'h00, 1);
    add(0, 1, 8'h21, 2, 0, 8'h00, 1);
    add(1, 1, 8'h99, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 1);
    add(0, 1, 8'h31, 0, 0, 8'h00, 1);
    add(0, 1, 8'h41, 2, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 0, 8'hFF, 1);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0;
    out_ready = '0; v6 = 1'b0; d6 = '0; s6 = '0; b6 = 1'b0; or6 = '0;
    @(posedge clk); #1;

    foreach (tbl[i]) step(tbl[i]);

    // 4: illegal selects on a 6-channel router with a 2-bit saturating counter
    rst_n = 1'b1; in_valid = 1'b0; out_ready = '0;
    cyc6(1, 8'h60, 6, 0, 1);
    cyc6(1, 8'h61, 7, 0, 1);
    cyc6(0, 8'h00, 0, 0, 1);
    cyc6(1, 8'h62, 6, 0, 1);
    cyc6(1, 8'h63, 7, 0, 1);
    cyc6(1, 8'h64, 6, 0, 1);
    cyc6(1, 8'h65, 2, 0, 1);
    cyc6(1, 8'h66, 0, 1, 1);
    cyc6(0, 8'h00, 0, 0, 1);
    chk("od6_ch2", {24'd0, od6[2*8 +: 8]}, 32'h65);
    chk("od6_ch4", {24'd0, od6[4*8 +: 8]}, 32'h66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
